uart_rx_ctrl: RTL and testbench

Controller that sequences the UART receiver. It owns the receiver's rx_start and frame-config inputs, and detects frame start and completion. It latches a sticky per-frame error, and buffers received bytes with error flags in a show-ahead FIFO for the host. It sits between the host/register interface and the receiver, in the receiver's oversample clock domain (16 ticks per bit).

---
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver, applies frame config only between frames, and buffers bytes plus error flags for the host.
// Latency: a received byte is visible on rd_* the cycle after rx_done; staged config reaches the receiver one cycle after an idle opportunity.
// Backpressure: none toward the receiver; a frame arriving on a full FIFO with no same-cycle pop is dropped and counted in ovf_cnt.
module uart_rx_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                     rx_clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     en,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_length,
    input  logic                     cfg_parity_type,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_stop2,
    output logic                     cfg_err,
    output logic                     rx_start,
    output logic [3:0]               length,
    output logic                     parity_type,
    output logic                     parity_en,
    output logic                     stop2,
    input  logic                     rx_done,
    input  logic                     rx_error,
    input  logic [7:0]               rx_out,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               err_cnt,
    output logic [7:0]               ovf_cnt,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_OFF, S_ARM, S_FRAME} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            frame_err;
    logic            timeout;
    logic            push_req;
    logic            err_now;

    logic [3:0]      sh_length;
    logic            sh_parity_type;
    logic            sh_parity_en;
    logic            sh_stop2;
    logic            cfg_pend;
    logic            cfg_legal;
    logic            apply_ok;

    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            ovf;

    assign timeout   = (state == S_FRAME) && !rx_done && (timer == TW'(TIMEOUT - 1));
    assign push_req  = (state == S_FRAME) && rx_done;
    // An error flagged on the completion cycle itself still marks the frame.
    assign err_now   = frame_err | rx_error;
    assign cfg_legal = (cfg_length >= 4'd5) && (cfg_length <= 4'd8);
    // Only safe to retune the receiver when no frame can be in flight.
    assign apply_ok  = (state == S_OFF) || ((state == S_ARM) && rx);

    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = rd_en && (count != '0);
    assign push_ok   = push_req && (!full || pop);
    assign ovf       = push_req && full && !pop;

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign rd_err     = rd_valid ? mem[rd_ptr][8]   : 1'b0;
    assign fifo_count = count;

    // State register
    always_ff @(posedge rx_clk) begin
        if (rst) state <= S_OFF;
        else     state <= state_nxt;
    end

    // Next-state: a frame always runs to rx_done or timeout, en is only honoured outside FRAME
    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:   if (en) state_nxt = S_ARM;
            S_ARM:   begin
                if (!en)     state_nxt = S_OFF;
                else if (!rx) state_nxt = S_FRAME;
            end
            S_FRAME: if (rx_done || timeout) state_nxt = en ? S_ARM : S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        rx_start = (state == S_ARM) || (state == S_FRAME);
        busy     = (state == S_FRAME);
    end

    // Frame timer and sticky error, both restarted while armed so they are clean on FRAME entry
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            timer     <= '0;
            frame_err <= 1'b0;
        end else if (state == S_FRAME) begin
            timer <= timer + TW'(1);
            if (rx_error) frame_err <= 1'b1;
        end else begin
            timer     <= '0;
            frame_err <= 1'b0;
        end
    end

    // Config shadow: stage legal writes, apply at the next idle opportunity
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            sh_length      <= 4'd8;
            sh_parity_type <= 1'b0;
            sh_parity_en   <= 1'b0;
            sh_stop2       <= 1'b0;
            cfg_pend       <= 1'b0;
            length         <= 4'd8;
            parity_type    <= 1'b0;
            parity_en      <= 1'b0;
            stop2          <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_legal;
            if (cfg_pend && apply_ok) begin
                length      <= sh_length;
                parity_type <= sh_parity_type;
                parity_en   <= sh_parity_en;
                stop2       <= sh_stop2;
            end
            // A write coinciding with an apply keeps pending set so it lands next opportunity.
            if (cfg_we && cfg_legal) begin
                sh_length      <= cfg_length;
                sh_parity_type <= cfg_parity_type;
                sh_parity_en   <= cfg_parity_en;
                sh_stop2       <= cfg_stop2;
                cfg_pend       <= 1'b1;
            end else if (cfg_pend && apply_ok) begin
                cfg_pend <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because reads are gated by occupancy
    always_ff @(posedge rx_clk) begin
        if (push_ok) mem[wr_ptr] <= {err_now, rx_out};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push_ok) count <= count - (AW+1)'(1);
        end
    end

    // Saturating error and overflow counters
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
            ovf_cnt <= 8'd0;
        end else begin
            if (((push_req && err_now) || timeout) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (ovf && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a transaction-level model (byte queue, counters, staged config).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: the host pop is exercised alone and coincident with pushes at empty and full.
module tb_uart_rx_ctrl;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 256;

    logic       rx_clk = 1'b0;
    logic       rst, rx, en, cfg_we;
    logic [3:0] cfg_length;
    logic       cfg_parity_type, cfg_parity_en, cfg_stop2;
    logic       cfg_err, rx_start;
    logic [3:0] length;
    logic       parity_type, parity_en, stop2;
    logic       rx_done, rx_error;
    logic [7:0] rx_out;
    logic       rd_en, rd_valid;
    logic [7:0] rd_data;
    logic       rd_err;
    logic [3:0] fifo_count;
    logic [7:0] err_cnt, ovf_cnt;
    logic       busy;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .rx_clk(rx_clk), .rst(rst), .rx(rx), .en(en),
        .cfg_we(cfg_we), .cfg_length(cfg_length), .cfg_parity_type(cfg_parity_type),
        .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2), .cfg_err(cfg_err),
        .rx_start(rx_start), .length(length), .parity_type(parity_type),
        .parity_en(parity_en), .stop2(stop2),
        .rx_done(rx_done), .rx_error(rx_error), .rx_out(rx_out),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .fifo_count(fifo_count), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt), .busy(busy)
    );

    always #5 rx_clk = ~rx_clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [8:0] mq[$];
    int m_err, m_ovf;
    int m_len, m_pt, m_pe, m_s2;
    int p_len, p_pt, p_pe, p_s2;
    bit p_vld;
    // Config values used by the next frame that writes config
    int cw_len, cw_pt, cw_pe, cw_s2;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 0; m_ovf = 0;
        m_len = 8; m_pt = 0; m_pe = 0; m_s2 = 0;
        p_vld = 0;
    endtask

    // opp: this edge is a moment with no frame possibly in flight, so staged config lands
    task automatic tick(input bit opp);
        @(posedge rx_clk);
        if (opp && p_vld) begin
            m_len = p_len; m_pt = p_pt; m_pe = p_pe; m_s2 = p_s2;
            p_vld = 0;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_valid"}, rd_valid, mq.size() > 0);
        chk({tag, ".count"}, fifo_count, mq.size());
        chk({tag, ".rd_data"}, rd_data, mq.size() > 0 ? int'(mq[0][7:0]) : 0);
        chk({tag, ".rd_err"}, rd_err, mq.size() > 0 ? int'(mq[0][8]) : 0);
        chk({tag, ".err_cnt"}, err_cnt, m_err > 255 ? 255 : m_err);
        chk({tag, ".ovf_cnt"}, ovf_cnt, m_ovf > 255 ? 255 : m_ovf);
        chk({tag, ".length"}, length, m_len);
        chk({tag, ".parity_type"}, parity_type, m_pt);
        chk({tag, ".parity_en"}, parity_en, m_pe);
        chk({tag, ".stop2"}, stop2, m_s2);
    endtask

    task automatic do_pop();
        if (mq.size() > 0) begin
            chk("pop.head", rd_data, mq[0][7:0]);
            void'(mq.pop_front());
        end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    // One received frame: start bit, len cycles of reception, then rx_done.
    // wcfg: 0 none, 1 legal write of cw_*, 2 illegal length write. en_off drops en mid-frame.
    task automatic do_frame(input logic [7:0] data, input int err_at, input int len,
                            input bit pop, input int wcfg, input bit en_off);
        bit is_err;
        is_err = (err_at >= 0);
        chk("frm.armed", rx_start && !busy, 1);
        rx = 1'b0;
        tick(0);
        rx = 1'b1;
        for (int i = 0; i < len; i++) begin
            cfg_we = 1'b0;
            if (i == 0 && wcfg != 0) begin
                cfg_we          = 1'b1;
                cfg_length      = (wcfg == 1) ? 4'(cw_len) : 4'(cw_len);
                cfg_parity_type = cw_pt[0];
                cfg_parity_en   = cw_pe[0];
                cfg_stop2       = cw_s2[0];
                if (wcfg == 1) begin
                    p_len = cw_len; p_pt = cw_pt; p_pe = cw_pe; p_s2 = cw_s2; p_vld = 1;
                end
            end
            if (i == 1 && wcfg != 0) begin
                chk("frm.cfg_err", cfg_err, wcfg == 2);
                chk("frm.len_hold", length, m_len);
                chk("frm.pe_hold", parity_en, m_pe);
            end
            if (i == 2 && wcfg != 0) chk("frm.cfg_err_clr", cfg_err, 0);
            if (i == len / 2) chk("frm.busy", busy, 1);
            if (i == 1 && en_off) en = 1'b0;
            rx_error = (i == err_at);
            tick(0);
        end
        cfg_we   = 1'b0;
        rx_error = 1'b0;
        rx_done  = 1'b1;
        rx_out   = data;
        rd_en    = pop;
        if (pop && mq.size() > 0) begin
            chk("frm.pop_head", rd_data, mq[0][7:0]);
            void'(mq.pop_front());
        end
        if (mq.size() < DEPTH) mq.push_back({is_err, data});
        else m_ovf++;
        if (is_err) m_err++;
        tick(0);
        rx_done = 1'b0;
        rd_en   = 1'b0;
        chk("frm.end_busy", busy, 0);
        chk("frm.end_rx_start", rx_start, en);
    endtask

    task automatic do_timeout();
        rx = 1'b0;
        tick(0);
        rx = 1'b1;
        for (int i = 0; i < TIMEOUT - 1; i++) tick(0);
        chk("to.busy_last", busy, 1);
        tick(0);
        m_err++;
        chk("to.busy_after", busy, 0);
        chk("to.rearm", rx_start, 1);
        check_all("to");
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_length = 4'd8;
        cfg_parity_type = 1'b0; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        rx_done = 1'b0; rx_error = 1'b0; rx_out = 8'h00; rd_en = 1'b0;
        model_reset();
        tick(0);
        tick(0);
        chk("rst.rx_start", rx_start, 0);
        chk("rst.busy", busy, 0);
        chk("rst.cfg_err", cfg_err, 0);
        check_all("rst");

        // Enable: armed one cycle later
        rst = 1'b0;
        en  = 1'b1;
        chk("en.before", rx_start, 0);
        tick(1);
        chk("en.rx_start", rx_start, 1);

        // Basic 8N1 frame, then pop
        do_frame(8'hA5, -1, 160, 0, 0, 0);
        check_all("a5");
        do_pop();
        check_all("a5.pop");

        // Legal config written mid-frame is held until an idle opportunity
        cw_len = 7; cw_pt = 0; cw_pe = 1; cw_s2 = 0;
        do_frame(8'h11, -1, 20, 0, 1, 0);
        chk("cfg.held_at_end", length, 8);
        tick(1);
        check_all("cfg.applied");
        chk("cfg.len7", length, 7);
        // Illegal length: pulse, config unchanged
        cw_len = 9; cw_pt = 1; cw_pe = 0; cw_s2 = 1;
        do_frame(8'h22, -1, 20, 0, 2, 0);
        tick(1);
        check_all("cfg.illegal");

        // Errored frame
        do_frame(8'h3C, 5, 20, 0, 0, 0);
        check_all("err");
        while (mq.size() > 0) do_pop();
        check_all("drain1");

        // Overflow: DEPTH+2 frames, then push+pop at full
        for (int k = 0; k < DEPTH + 2; k++) do_frame(8'(k + 1), -1, 4, 0, 0, 0);
        check_all("ovf");
        chk("ovf.count", fifo_count, 8);
        chk("ovf.cnt", ovf_cnt, 2);
        chk("ovf.head", rd_data, 1);
        do_frame(8'h77, -1, 4, 1, 0, 0);
        check_all("ovf.pushpop");
        while (mq.size() > 0) do_pop();

        // Empty FIFO with push and pop together: pop ignored
        do_frame(8'h5A, -1, 6, 1, 0, 0);
        check_all("empty.pushpop");

        // Timeout
        do_timeout();

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act < 6) begin
                int wc;
                wc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
                cw_len = (wc == 2) ? (($urandom_range(0, 1) == 1) ? int'($urandom_range(9, 15))
                                                                  : int'($urandom_range(0, 4)))
                                   : int'($urandom_range(5, 8));
                cw_pt = $urandom_range(0, 1); cw_pe = $urandom_range(0, 1); cw_s2 = $urandom_range(0, 1);
                do_frame(8'($urandom_range(0, 255)),
                         ($urandom_range(0, 3) == 0) ? 2 : -1,
                         $urandom_range(3, 30), $urandom_range(0, 3) == 0, wc, 0);
            end else if (act < 9) begin
                do_pop();
            end else begin
                tick(1);
            end
            check_all("rnd");
        end

        // Graceful disable: frame completes, then OFF
        do_frame(8'hC3, -1, 10, 0, 0, 1);
        chk("dis.off", rx_start, 0);
        check_all("dis");
        en = 1'b1;
        tick(1);
        chk("dis.rearm", rx_start, 1);

        // Reset mid-frame discards everything, including staged config
        rx = 1'b0;
        tick(0);
        rx = 1'b1;
        cfg_we = 1'b1; cfg_length = 4'd6; cfg_parity_en = 1'b1;
        tick(0);
        cfg_we = 1'b0;
        tick(0);
        rst = 1'b1;
        tick(0);
        model_reset();
        chk("mrst.rx_start", rx_start, 0);
        chk("mrst.busy", busy, 0);
        chk("mrst.cfg_err", cfg_err, 0);
        check_all("mrst");
        rst = 1'b0;
        tick(1);
        tick(1);
        chk("mrst.rearm", rx_start, 1);
        check_all("mrst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
